// File: rtl/hamming_pkg.sv
// rtl/hamming_pkg.sv - Hamming code geometry, syndrome helpers and error classes
// Position space: bit k of a vector is Hamming position k, bit 0 is the overall parity slot.
package hamming_pkg;

  typedef enum logic [1:0] {
    CLEAN  = 2'd0,
    CORR   = 2'd1,
    UNCORR = 2'd2
  } err_class_e;

  function automatic int calc_p(input int data_w);
    int p;
    p = 0;
    for (int i = 1; i < 32; i++) begin
      if (p == 0 && (1 << i) >= data_w + i + 1) p = i;
    end
    return p;
  endfunction

  function automatic bit is_pow2(input int k);
    return (k > 0) && ((k & (k - 1)) == 0);
  endfunction

  // Hamming position of data bit j: the j-th non-power-of-two position from 3 upward.
  function automatic int data_pos(input int j);
    int cnt;
    int pos;
    cnt = 0;
    pos = 0;
    for (int k = 3; k < 512; k++) begin
      if (!is_pow2(k)) begin
        if (cnt == j && pos == 0) pos = k;
        cnt++;
      end
    end
    return pos;
  endfunction

  function automatic int data_idx(input int pos);
    int idx;
    idx = -1;
    for (int j = 0; j < 256; j++) begin
      if (idx < 0 && data_pos(j) == pos) idx = j;
    end
    return idx;
  endfunction

  function automatic int calc_syndrome(input logic [255:0] cw, input int n);
    int s;
    s = 0;
    for (int k = 1; k < 256; k++) begin
      if (k <= n && cw[k]) s = s ^ k;
    end
    return s;
  endfunction

  function automatic logic [255:0] extract_data(input logic [255:0] cw, input int data_w);
    logic [255:0] d;
    int j;
    d = '0;
    j = 0;
    for (int k = 3; k < 256; k++) begin
      if (!is_pow2(k) && j < data_w) begin
        d[j] = cw[k];
        j++;
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/hamming_secded_dec_if.sv
// rtl/hamming_secded_dec_if.sv - codeword in / payload out stream bundle of the decoder
interface hamming_secded_dec_if #(
  parameter int DATA_W = 16,
  parameter int DED_EN = 1
);
  import hamming_pkg::*;

  localparam int P    = calc_p(DATA_W);
  localparam int N    = DATA_W + P;
  localparam int CW_W = N + DED_EN;

  logic [CW_W-1:0]   i_data;
  logic              i_valid;
  logic              o_ready;
  logic [DATA_W-1:0] o_data;
  logic              o_valid;
  logic              i_ready;
  logic              o_err_corr;
  logic              o_err_uncorr;
  logic [P-1:0]      o_syndrome;

  modport master (
    output i_data, i_valid, i_ready,
    input  o_ready, o_data, o_valid, o_err_corr, o_err_uncorr, o_syndrome
  );

  modport slave (
    input  i_data, i_valid, i_ready,
    output o_ready, o_data, o_valid, o_err_corr, o_err_uncorr, o_syndrome
  );

endinterface

// File: rtl/hamming_syndrome.sv
// rtl/hamming_syndrome.sv - combinational syndrome, error classification and data correction
module hamming_syndrome
  import hamming_pkg::*;
#(
  parameter int  DATA_W = 16,
  parameter int  DED_EN = 1,
  localparam int P      = calc_p(DATA_W),
  localparam int N      = DATA_W + P,
  localparam int CW_W   = N + DED_EN
) (
  input  logic [CW_W-1:0]   i_cw,
  output logic [DATA_W-1:0] o_data,
  output logic [P-1:0]      o_syndrome,
  output err_class_e        o_class
);

  logic [N:0]   w_pos;
  logic [N:0]   w_corr;
  logic [P-1:0] w_syn;
  logic         w_pf;
  logic         w_in_range;
  logic         w_flip;

  // Without the overall bit the codeword starts at position 1, so shift it into position space.
  if (DED_EN != 0) begin : g_ded
    assign w_pos = i_cw;
  end else begin : g_sec
    assign w_pos = {i_cw, 1'b0};
  end

  assign w_syn      = P'(calc_syndrome(256'(w_pos), N));
  assign w_pf       = ^w_pos;
  assign w_in_range = (w_syn != '0) && (int'(w_syn) <= N);

  always_comb begin
    o_class = CLEAN;
    w_flip  = 1'b0;
    if (DED_EN != 0) begin
      if (w_pf) begin
        if (w_syn == '0) begin
          o_class = CORR;
        end else if (w_in_range) begin
          o_class = CORR;
          w_flip  = 1'b1;
        end else begin
          o_class = UNCORR;
        end
      end else if (w_syn != '0) begin
        o_class = UNCORR;
      end
    end else begin
      if (w_in_range) begin
        o_class = CORR;
        w_flip  = 1'b1;
      end else if (w_syn != '0) begin
        o_class = UNCORR;
      end
    end
  end

  assign w_corr     = w_pos ^ (w_flip ? ((N + 1)'(1) << w_syn) : '0);
  assign o_data     = DATA_W'(extract_data(256'(w_corr), DATA_W));
  assign o_syndrome = w_syn;

endmodule

// File: rtl/hamming_secded_dec.sv
// rtl/hamming_secded_dec.sv - two-stage SEC/SECDED Hamming decoder with backpressure and error counters
module hamming_secded_dec
  import hamming_pkg::*;
#(
  parameter int  DATA_W = 16,
  parameter int  DED_EN = 1,
  parameter int  CNT_W  = 16,
  localparam int P      = calc_p(DATA_W),
  localparam int N      = DATA_W + P,
  localparam int CW_W   = N + DED_EN
) (
  input  logic                clk,
  input  logic                rst,
  hamming_secded_dec_if.slave bus,
  input  logic                i_cnt_clr,
  output logic [CNT_W-1:0]    o_cnt_corr,
  output logic [CNT_W-1:0]    o_cnt_uncorr
);

  logic              r_s1_valid;
  logic [CW_W-1:0]   r_s1_cw;
  logic              r_s2_valid;
  logic [DATA_W-1:0] r_s2_data;
  logic              r_s2_corr;
  logic              r_s2_uncorr;
  logic [P-1:0]      r_s2_syn;
  logic [CNT_W-1:0]  r_cnt_corr;
  logic [CNT_W-1:0]  r_cnt_uncorr;

  logic              w_s2_free;
  logic              w_accept;
  logic              w_out_hs;
  logic [DATA_W-1:0] w_data;
  logic [P-1:0]      w_syn;
  err_class_e        w_class;

  assign w_s2_free   = !r_s2_valid || bus.i_ready;
  assign bus.o_ready = !r_s1_valid || w_s2_free;
  assign w_accept    = bus.i_valid && bus.o_ready;
  assign w_out_hs    = r_s2_valid && bus.i_ready;

  hamming_syndrome #(
    .DATA_W (DATA_W),
    .DED_EN (DED_EN)
  ) u_syndrome (
    .i_cw       (r_s1_cw),
    .o_data     (w_data),
    .o_syndrome (w_syn),
    .o_class    (w_class)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1_valid  <= 1'b0;
      r_s1_cw     <= '0;
      r_s2_valid  <= 1'b0;
      r_s2_data   <= '0;
      r_s2_corr   <= 1'b0;
      r_s2_uncorr <= 1'b0;
      r_s2_syn    <= '0;
    end else begin
      if (bus.o_ready) begin
        r_s1_valid <= bus.i_valid;
      end
      if (w_accept) begin
        r_s1_cw <= bus.i_data;
      end
      if (w_s2_free) begin
        r_s2_valid <= r_s1_valid;
      end
      // Result registers only move on a real transfer so a stalled output stays put.
      if (w_s2_free && r_s1_valid) begin
        r_s2_data   <= w_data;
        r_s2_corr   <= (w_class == CORR);
        r_s2_uncorr <= (w_class == UNCORR);
        r_s2_syn    <= w_syn;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt_corr   <= '0;
      r_cnt_uncorr <= '0;
    end else if (i_cnt_clr) begin
      r_cnt_corr   <= '0;
      r_cnt_uncorr <= '0;
    end else begin
      if (w_out_hs && r_s2_corr && !(&r_cnt_corr)) begin
        r_cnt_corr <= r_cnt_corr + CNT_W'(1);
      end
      if (w_out_hs && r_s2_uncorr && !(&r_cnt_uncorr)) begin
        r_cnt_uncorr <= r_cnt_uncorr + CNT_W'(1);
      end
    end
  end

  assign bus.o_valid      = r_s2_valid;
  assign bus.o_data       = r_s2_data;
  assign bus.o_err_corr   = r_s2_corr;
  assign bus.o_err_uncorr = r_s2_uncorr;
  assign bus.o_syndrome   = r_s2_syn;
  assign o_cnt_corr       = r_cnt_corr;
  assign o_cnt_uncorr     = r_cnt_uncorr;

endmodule

// File: tb/tb_hamming_secded_dec.sv
// tb/tb_hamming_secded_dec.sv - directed-vector bench for hamming_secded_dec
module tb_hamming_secded_dec;

  logic       clk;
  logic       rst;
  logic       i_cnt_clr;
  logic [1:0] o_cnt_corr;
  logic [1:0] o_cnt_uncorr;

  int n_cmp;
  int n_bad;

  hamming_secded_dec_if #(.DATA_W(16), .DED_EN(1)) bus ();

  hamming_secded_dec #(
    .DATA_W (16),
    .DED_EN (1),
    .CNT_W  (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .i_cnt_clr    (i_cnt_clr),
    .o_cnt_corr   (o_cnt_corr),
    .o_cnt_uncorr (o_cnt_uncorr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [21:0] vec_cw   [6] = '{22'h000000, 22'h3FFFFC, 22'h000020, 22'h000001, 22'h000028, 22'h010103};
  logic [15:0] vec_data [6] = '{16'h0000, 16'hFFFF, 16'h0000, 16'h0000, 16'h0003, 16'h0000};
  logic        vec_corr [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
  logic        vec_unc  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  logic [4:0]  vec_syn  [6] = '{5'd0, 5'd0, 5'd5, 5'd0, 5'd6, 5'd25};

  logic [21:0] bp_cw  [5] = '{22'h00000F, 22'h000033, 22'h000055, 22'h000096, 22'h3FFFFC};
  logic [15:0] bp_exp [5] = '{16'h0001, 16'h0002, 16'h0004, 16'h0008, 16'hFFFF};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          tx;
    int          rx;
    logic        in_hs;
    logic        out_hs;
    logic [15:0] out_d;
    logic [15:0] held;

    n_cmp = 0;
    n_bad = 0;
    rst = 1'b0;
    i_cnt_clr = 1'b0;
    bus.i_data = '0;
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    held = '0;

    repeat (2) step();
    chk("rst_valid",  32'(bus.o_valid), 32'd0);
    chk("rst_data",   32'(bus.o_data), 32'd0);
    chk("rst_corr",   32'(bus.o_err_corr), 32'd0);
    chk("rst_uncorr", 32'(bus.o_err_uncorr), 32'd0);
    chk("rst_syn",    32'(bus.o_syndrome), 32'd0);
    chk("rst_cnt_c",  32'(o_cnt_corr), 32'd0);
    chk("rst_cnt_u",  32'(o_cnt_uncorr), 32'd0);
    rst = 1'b1;
    #1;
    chk("rst_ready", 32'(bus.o_ready), 32'd1);

    // Isolated words: latency 2, then the next drive step drains each one.
    for (int v = 0; v < 6; v++) begin
      bus.i_data = vec_cw[v];
      bus.i_valid = 1'b1;
      step();
      bus.i_valid = 1'b0;
      chk("vec_lat1", 32'(bus.o_valid), 32'd0);
      step();
      chk("vec_valid",  32'(bus.o_valid), 32'd1);
      chk("vec_data",   32'(bus.o_data), 32'(vec_data[v]));
      chk("vec_corr",   32'(bus.o_err_corr), 32'(vec_corr[v]));
      chk("vec_uncorr", 32'(bus.o_err_uncorr), 32'(vec_unc[v]));
      chk("vec_syn",    32'(bus.o_syndrome), 32'(vec_syn[v]));
    end
    step();
    step();
    chk("vec_cnt_c", 32'(o_cnt_corr), 32'd2);
    chk("vec_cnt_u", 32'(o_cnt_uncorr), 32'd2);

    // Backpressure: i_ready low for cycles 3..6 while streaming five clean words.
    tx = 0;
    rx = 0;
    for (int c = 0; c < 30 && rx < 5; c++) begin
      bus.i_valid = (tx < 5);
      bus.i_data = bp_cw[(tx < 5) ? tx : 0];
      bus.i_ready = !(c >= 3 && c <= 6);
      #1;
      in_hs = bus.i_valid && bus.o_ready;
      out_hs = bus.o_valid && bus.i_ready;
      out_d = bus.o_data;
      if (c == 3) held = bus.o_data;
      if (c >= 3 && c <= 6) begin
        chk("bp_ready_low", 32'(bus.o_ready), 32'd0);
        chk("bp_hold", 32'(bus.o_data), 32'(held));
      end
      step();
      if (in_hs) tx++;
      if (out_hs) begin
        chk("bp_order", 32'(out_d), 32'(bp_exp[rx]));
        rx++;
      end
    end
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    chk("bp_count", 32'(rx), 32'd5);
    step();
    step();
    chk("bp_no_dup", 32'(bus.o_valid), 32'd0);

    i_cnt_clr = 1'b1;
    step();
    i_cnt_clr = 1'b0;
    chk("clr_cnt_c", 32'(o_cnt_corr), 32'd0);
    chk("clr_cnt_u", 32'(o_cnt_uncorr), 32'd0);

    for (int i = 0; i < 5; i++) begin
      bus.i_data = 22'h000020;
      bus.i_valid = 1'b1;
      step();
    end
    bus.i_valid = 1'b0;
    repeat (3) step();
    chk("sat_cnt_c", 32'(o_cnt_corr), 32'd3);
    chk("sat_cnt_u", 32'(o_cnt_uncorr), 32'd0);

    // Clear lands on the same edge as a corrected handshake.
    bus.i_data = 22'h000001;
    bus.i_valid = 1'b1;
    step();
    bus.i_valid = 1'b0;
    step();
    chk("clrhs_pre", 32'(o_cnt_corr), 32'd3);
    i_cnt_clr = 1'b1;
    step();
    i_cnt_clr = 1'b0;
    chk("clrhs_cnt", 32'(o_cnt_corr), 32'd0);
    chk("clrhs_drained", 32'(bus.o_valid), 32'd0);

    bus.i_data = 22'h010103;
    bus.i_valid = 1'b1;
    step();
    bus.i_valid = 1'b0;
    step();
    step();
    chk("unc_cnt", 32'(o_cnt_uncorr), 32'd1);

    // Fill both stages, then reset asynchronously between edges.
    bus.i_ready = 1'b0;
    bus.i_data = 22'h000020;
    bus.i_valid = 1'b1;
    step();
    step();
    bus.i_valid = 1'b0;
    chk("full_valid", 32'(bus.o_valid), 32'd1);
    chk("full_ready", 32'(bus.o_ready), 32'd0);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_valid", 32'(bus.o_valid), 32'd0);
    chk("arst_cnt_u", 32'(o_cnt_uncorr), 32'd0);
    chk("arst_ready", 32'(bus.o_ready), 32'd1);
    step();
    rst = 1'b1;
    bus.i_ready = 1'b1;
    #1;
    chk("rel_ready", 32'(bus.o_ready), 32'd1);
    step();
    chk("rel_flushed", 32'(bus.o_valid), 32'd0);
    bus.i_data = 22'h00000F;
    bus.i_valid = 1'b1;
    step();
    bus.i_valid = 1'b0;
    chk("rel_lat1", 32'(bus.o_valid), 32'd0);
    step();
    chk("rel_valid", 32'(bus.o_valid), 32'd1);
    chk("rel_data",  32'(bus.o_data), 32'h0001);
    chk("rel_corr",  32'(bus.o_err_corr), 32'd0);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hamming_secded_dec.md
Name: hamming_secded_dec

Overview:
- Parametrised pipelined Hamming decoder, next generation of the fixed 21-bit/16-bit decoder in the link receive path.
- Generalised data width, optional extended-parity (SECDED) mode, proper valid/ready backpressure, error classification outputs and saturating error counters.
- Sits between the deserialiser/frame unpacker and the payload FIFO.

Parameters:
- DATA_W, 16, payload width (≥4).
- DED_EN, 1, 1 = extended Hamming with overall parity bit at codeword index 0 (SECDED); 0 = plain SEC, no index-0 bit.
- CNT_W, 16, width of each error counter.
- Derived: P = smallest P with 2^P ≥ DATA_W+P+1; N = DATA_W+P (highest Hamming position); CW_W = N+DED_EN. DATA_W=16 gives P=5, N=21, CW_W=22.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- i_data  in  CW_W  codeword; bit k = Hamming position k (k=1..N); bit 0 = overall parity when DED_EN=1.
- i_valid  in  1  codeword valid.
- o_ready  out  1  decoder can accept a codeword.
- o_data  out  DATA_W  decoded payload.
- o_valid  out  1  payload valid.
- i_ready  in  1  downstream accepts.
- o_err_corr  out  1  single error corrected (qualified by o_valid).
- o_err_uncorr  out  1  uncorrectable error (qualified by o_valid).
- o_syndrome  out  P  syndrome of this word (qualified by o_valid).
- i_cnt_clr  in  1  synchronous clear of both counters.
- o_cnt_corr  out  CNT_W  saturating count of corrected words.
- o_cnt_uncorr  out  CNT_W  saturating count of uncorrectable words.

Behaviour:
- Reset (rst=0, asynchronous): both stage valids 0, o_valid=0, o_data=0, flags=0, o_syndrome=0, counters 0. o_ready=1 from the first cycle after release.
- Layout: parity bits at positions 2^k, k=0..P-1. Data bit j occupies the j-th non-power-of-two position, in ascending order; data[0] is at position 3. Even parity throughout. Parity bit 2^k covers all positions with address bit k set. The overall bit makes bits 0..N even.
- Pipeline: 2 stages, latency 2 cycles from the accept cycle (i_valid & o_ready) to o_valid.
  - S1 registers the codeword.
  - S2 registers the corrected data, flags and syndrome.
- Handshake:
  - A stage advances when its successor is empty or is being emptied.
  - o_ready = !s1_valid | s1_advance; combinational from i_ready is allowed.
  - o_data, flags and syndrome are held stable while o_valid & !i_ready.
  - Full throughput of 1 word/cycle when i_ready=1. No word is lost or duplicated.
- Syndrome s = XOR of the addresses of all set bits at positions 1..N. pf = XOR of bits 0..N.
- Classification, DED_EN=1:
  - s=0, pf=0: clean.
  - pf=1, 1≤s≤N: flip position s, corr=1.
  - pf=1, s=0: error in bit 0, data unchanged, corr=1.
  - pf=0, s≠0: uncorr=1, data passed raw.
  - pf=1, s>N: uncorr=1, data raw.
- Classification, DED_EN=0:
  - s=0: clean.
  - 1≤s≤N: correct, corr=1.
  - s>N: uncorr=1.
- corr and uncorr are never both 1.
- Counters:
  - Increment on the output handshake (o_valid & i_ready) when the matching flag is set.
  - Saturate at 2^CNT_W-1.
  - i_cnt_clr takes priority over an increment in the same cycle.
- Reset mid-stream flushes both stages. Words in flight are discarded and not counted.

Decomposition:
- Package hamming_pkg holds:
  - the function computing P from DATA_W;
  - functions mapping data index ↔ Hamming position;
  - the syndrome function;
  - the error-class enum (CLEAN, CORR, UNCORR).
- One sub-module, hamming_syndrome: combinational syndrome, pf and corrected-data generation. It is reused by the future encoder checker.
- The top level holds pipeline registers, handshake and counters.

Test Plan (DATA_W=16, DED_EN=1, CNT_W=2 unless stated):
- Clean words: 22'h000000 then 22'h3FFFFC, i_ready=1 → o_data 16'h0000 then 16'hFFFF at accept+2, no flags, syndrome 0.
- Single errors:
  - 22'h000020 → o_data 16'h0000, corr=1, syndrome 5.
  - 22'h000001 → o_data 16'h0000, corr=1, syndrome 0.
- Uncorrectable words:
  - 22'h000028 → o_data 16'h0003, uncorr=1, syndrome 6.
  - 22'h010103 → uncorr=1, syndrome 25.
- Backpressure: stream 5 clean words while holding i_ready=0 for 4 cycles mid-stream → o_ready drops after 2 buffered words, output held stable, all 5 delivered in order, none duplicated.
- Counters: 5 corrected words → o_cnt_corr saturates at 3. i_cnt_clr together with a corrected handshake → 0.
- Reset: assert rst low with both stages full → o_valid=0 and counters 0 immediately (asynchronous). After release o_ready=1 and the next word decodes with latency 2.
